// File: rtl/branch_resolve_ctrl_pkg.sv
// rtl/branch_resolve_ctrl_pkg.sv - shared branch funct3 codes and controller state encoding
package branch_resolve_ctrl_pkg;

    localparam logic [2:0] BEQ  = 3'b000;
    localparam logic [2:0] BNE  = 3'b001;
    localparam logic [2:0] BLT  = 3'b100;
    localparam logic [2:0] BGE  = 3'b101;
    localparam logic [2:0] BLTU = 3'b110;
    localparam logic [2:0] BGEU = 3'b111;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RESOLVE  = 2'd1,
        REDIRECT = 2'd2
    } state_t;

endpackage

// File: rtl/branch_resolve_ctrl_if.sv
// rtl/branch_resolve_ctrl_if.sv - decode/fetch facing branch, result and redirect signals
interface branch_resolve_ctrl_if #(
    parameter int XLEN = 32
);

    logic            br_valid;
    logic            br_ready;
    logic [XLEN-1:0] br_pc;
    logic [XLEN-1:0] br_imm;
    logic [2:0]      br_funct3;
    logic            br_pred_taken;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;

    logic            res_valid;
    logic            res_taken;
    logic            illegal;
    logic            flush;

    logic            redirect_valid;
    logic            redirect_ready;
    logic [XLEN-1:0] redirect_pc;

    modport master (
        output br_valid, br_pc, br_imm, br_funct3, br_pred_taken, rs1_data, rs2_data,
        output redirect_ready,
        input  br_ready, res_valid, res_taken, illegal, flush,
        input  redirect_valid, redirect_pc
    );

    modport slave (
        input  br_valid, br_pc, br_imm, br_funct3, br_pred_taken, rs1_data, rs2_data,
        input  redirect_ready,
        output br_ready, res_valid, res_taken, illegal, flush,
        output redirect_valid, redirect_pc
    );

endinterface

// File: rtl/branch_comp.sv
// rtl/branch_comp.sv - shared equality / less-than branch comparator
module branch_comp #(
    parameter int N = 32
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         br_un,
    output logic         br_eq,
    output logic         br_lt
);

    assign br_eq = (a == b);
    assign br_lt = br_un ? (a < b) : ($signed(a) < $signed(b));

endmodule

// File: rtl/branch_resolve_ctrl.sv
// rtl/branch_resolve_ctrl.sv - execute-stage conditional branch resolution controller
module branch_resolve_ctrl
    import branch_resolve_ctrl_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    branch_resolve_ctrl_if.slave bus,
    input  logic                 kill,
    input  logic                 clear_stats,
    output logic [CNT_W-1:0]     branch_cnt,
    output logic [CNT_W-1:0]     mispred_cnt
);

    state_t          state;
    state_t          state_nxt;

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] imm_q;
    logic [XLEN-1:0] rs1_q;
    logic [XLEN-1:0] rs2_q;
    logic [2:0]      funct3_q;
    logic            pred_q;
    logic [XLEN-1:0] redirect_pc_q;

    logic            br_eq;
    logic            br_lt;
    logic            taken;
    logic            legal;
    logic            in_resolve;
    logic            live;
    logic            mispredict;
    logic            ready;
    logic            accept;

    branch_comp #(.N(XLEN)) u_comp (
        .a     (rs1_q),
        .b     (rs2_q),
        .br_un (funct3_q[1]),
        .br_eq (br_eq),
        .br_lt (br_lt)
    );

    always_comb begin
        taken = 1'b0;
        legal = 1'b1;
        case (funct3_q)
            BEQ:        taken = br_eq;
            BNE:        taken = !br_eq;
            BLT, BLTU:  taken = br_lt;
            BGE, BGEU:  taken = !br_lt;
            default:    legal = 1'b0;
        endcase
    end

    // live gates every architecturally visible effect of the resolve cycle with kill
    assign in_resolve = (state == RESOLVE);
    assign live       = in_resolve && !kill;
    assign mispredict = in_resolve && legal && (taken != pred_q);

    // rst_n is folded in so the handshake output is also quiet while reset is held
    assign ready  = rst_n && !kill && ((state == IDLE) || (in_resolve && !mispredict));
    assign accept = bus.br_valid && ready;

    assign bus.br_ready       = ready;
    assign bus.res_valid      = live;
    assign bus.res_taken      = live && taken;
    assign bus.illegal        = live && !legal;
    assign bus.flush          = live && mispredict;
    assign bus.redirect_valid = (state == REDIRECT);
    assign bus.redirect_pc    = redirect_pc_q;

    always_comb begin
        state_nxt = state;
        if (kill) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) state_nxt = RESOLVE;
                end
                RESOLVE: begin
                    if (mispredict)  state_nxt = REDIRECT;
                    else if (accept) state_nxt = RESOLVE;
                    else             state_nxt = IDLE;
                end
                REDIRECT: begin
                    if (bus.redirect_ready) state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q     <= '0;
            imm_q    <= '0;
            rs1_q    <= '0;
            rs2_q    <= '0;
            funct3_q <= '0;
            pred_q   <= 1'b0;
        end else if (accept) begin
            pc_q     <= bus.br_pc;
            imm_q    <= bus.br_imm;
            rs1_q    <= bus.rs1_data;
            rs2_q    <= bus.rs2_data;
            funct3_q <= bus.br_funct3;
            pred_q   <= bus.br_pred_taken;
        end
    end

    // Captured on the flush cycle and held untouched for the whole REDIRECT wait
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            redirect_pc_q <= '0;
        end else if (bus.flush) begin
            redirect_pc_q <= taken ? (pc_q + imm_q) : (pc_q + XLEN'(4));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            branch_cnt  <= '0;
            mispred_cnt <= '0;
        end else if (clear_stats) begin
            branch_cnt  <= '0;
            mispred_cnt <= '0;
        end else begin
            if (live && legal && (branch_cnt != '1)) begin
                branch_cnt <= branch_cnt + CNT_W'(1);
            end
            if (bus.flush && (mispred_cnt != '1)) begin
                mispred_cnt <= mispred_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: doc/branch_resolve_ctrl.md
Name: branch_resolve_ctrl

Overview:
- Execute-stage branch resolution controller for the RISC-V core.
- Accepts one conditional branch at a time from decode and registers its operands. Drives the shared branch comparator (branch_comp, N=32) and decodes funct3 into taken/not-taken.
- Compares the actual outcome with fetch's static prediction. On a mispredict it issues a one-cycle flush and a held redirect to fetch.
- Keeps saturating branch and mispredict statistics counters.

Parameters:
XLEN, 32, datapath/PC width
CNT_W, 16, width of statistics counters

Ports:
clk  in  1  core clock
rst_n  in  1  reset, asynchronous, active-low
br_valid  in  1  decode presents a branch
br_ready  out  1  controller can accept a branch
br_pc  in  XLEN  PC of the branch
br_imm  in  XLEN  sign-extended B-immediate
br_funct3  in  3  branch funct3
br_pred_taken  in  1  fetch's prediction for this branch
rs1_data  in  XLEN  operand 1
rs2_data  in  XLEN  operand 2
kill  in  1  higher-priority squash (trap/interrupt)
res_valid  out  1  one-cycle pulse: branch resolved
res_taken  out  1  actual outcome, valid with res_valid
illegal  out  1  one-cycle pulse: funct3 010/011
flush  out  1  one-cycle pulse on mispredict
redirect_valid  out  1  redirect request to fetch
redirect_ready  in  1  fetch accepts redirect
redirect_pc  out  XLEN  corrected PC
clear_stats  in  1  synchronous counter clear
branch_cnt  out  CNT_W  resolved-branch count
mispred_cnt  out  CNT_W  mispredict count

Behaviour:
- Reset (rst_n low, async): state=IDLE. All outputs 0; counters 0; operand registers 0.
- States: IDLE, RESOLVE, REDIRECT.
- Accept happens when br_valid && br_ready. It registers pc, imm, funct3, pred, rs1, rs2 and the state becomes RESOLVE.
- RESOLVE (cycle after accept):
  - Comparator is fed from the registers, with BrUn = funct3[1].
  - Taken decode: 000 BrEq, 001 !BrEq, 100/110 BrLt, 101/111 !BrLt.
  - funct3 010/011: taken=0, illegal pulses, no mispredict is raised, counters unchanged.
  - res_valid pulses with res_taken. branch_cnt increments for legal funct3.
  - mispredict = legal && (taken != pred).
  - On mispredict: flush pulses this cycle, redirect_pc is latched, redirect_valid rises next cycle, mispred_cnt increments, and the state becomes REDIRECT.
  - Otherwise the state becomes IDLE, or stays RESOLVE if a new branch is accepted this cycle.
- redirect_pc = taken ? pc+imm : pc+4, modulo 2^XLEN (wrap, no overflow flag).
- br_ready = (state==IDLE) || (state==RESOLVE && !mispredict) — combinational, so correctly predicted branches sustain 1/cycle. br_ready=0 in REDIRECT and whenever kill=1.
- REDIRECT: redirect_valid and redirect_pc are held stable until redirect_ready. On handshake the state becomes IDLE and redirect_valid drops next cycle.
- kill (highest priority):
  - From any state the next state is IDLE and the pending redirect is dropped.
  - In a RESOLVE cycle, kill suppresses res_valid, flush, illegal and all counter updates.
  - A br_valid in the same cycle is not accepted.
- Counters:
  - Saturate at 2^CNT_W-1.
  - clear_stats zeroes both counters and wins over a same-cycle increment.
- Latency: accept→res_valid/flush = 1 cycle; accept→redirect_valid = 2 cycles.

Decomposition:
- Shared core package holds:
  - funct3 constants (BEQ, BNE, BLT, BGE, BLTU, BGEU)
  - state encoding (IDLE=0, RESOLVE=1, REDIRECT=2)
- Sub-module: the existing branch_comp, instantiated once. The controller adds no comparison logic of its own beyond the funct3 decode.

Test Plan:
- BEQ rs1=5, rs2=5, pred=1 → res_valid at T+1, res_taken=1, no flush; branch_cnt=1; br_ready stays 1 for a back-to-back branch.
- BLT rs1=0xFFFFFFFF, rs2=1, pred=0, pc=0x100, imm=0x20 → taken=1, flush at T+1. redirect_valid at T+2 with redirect_pc=0x120, held through 3 cycles of redirect_ready=0. mispred_cnt=1.
- BLTU rs1=0xFFFFFFFF, rs2=1, pred=1 → taken=0, flush; redirect_pc=pc+4. With pc=0xFFFFFFFC, redirect_pc=0x00000000 (wrap).
- funct3=010 → illegal pulse, res_taken=0, no flush, branch_cnt unchanged.
- Mispredict, then kill asserted while in REDIRECT → redirect_valid drops next cycle, state IDLE, br_ready=1. kill in a RESOLVE cycle → no res_valid/flush, counters unchanged.
- Preload branch_cnt to 0xFFFF via 65535 branches → next branch keeps 0xFFFF. clear_stats with a same-cycle resolve → 0. rst_n pulsed low mid-REDIRECT → all outputs 0 immediately.
